// File: rtl/tri_pkg.sv
// tri_pkg: shared constants, packet layout and types for the triangle setup
// stage (tri_setup and tri_bbox3).
package tri_pkg;

    localparam int PKT_W     = 144;
    localparam int COORD_W   = 16;
    localparam int FRAC_W    = 6;
    localparam int ATTR_W    = 48;
    localparam int EDGE_AB_W = 17;
    localparam int EDGE_C_W  = 33;
    localparam int AREA_W    = 35;
    localparam int INT_W     = COORD_W - FRAC_W;
    localparam int BBOX_W    = 4 * INT_W;
    localparam int CULL_W    = 16;

    // Packet field offsets
    localparam int OFS_V0X  = 0;
    localparam int OFS_V1X  = 16;
    localparam int OFS_V2X  = 32;
    localparam int OFS_V0Y  = 48;
    localparam int OFS_V1Y  = 64;
    localparam int OFS_V2Y  = 80;
    localparam int OFS_ATTR = 96;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } vertex_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_MUL,
        ST_AREA,
        ST_OUT
    } setup_state_e;

    function automatic vertex_t get_vertex(input logic [PKT_W-1:0] pkt, input int idx);
        vertex_t v;
        v.x = pkt[OFS_V0X + COORD_W*idx +: COORD_W];
        v.y = pkt[OFS_V0Y + COORD_W*idx +: COORD_W];
        return v;
    endfunction

    // Difference of two zero-extended coordinates; 17 bits holds any result.
    function automatic logic [EDGE_AB_W-1:0] coord_diff(input logic [COORD_W-1:0] p,
                                                        input logic [COORD_W-1:0] q);
        return {1'b0, p} - {1'b0, q};
    endfunction

endpackage

// File: rtl/tri_bbox3.sv
// tri_bbox3: combinational min/max of three unsigned 10.6 coordinates,
// returning integer parts only.
// Ports:
//   c0, c1, c2 : fixed-point coordinates
//   lo, hi     : floor(min), floor(max) as 10-bit integers
module tri_bbox3
    import tri_pkg::*;
(
    input  logic [COORD_W-1:0] c0,
    input  logic [COORD_W-1:0] c1,
    input  logic [COORD_W-1:0] c2,
    output logic [INT_W-1:0]   lo,
    output logic [INT_W-1:0]   hi
);

    logic [INT_W-1:0] i0, i1, i2;
    logic [INT_W-1:0] lo01, hi01;

    // Unsigned values: floor of the min equals the min of the floors.
    assign i0 = c0[COORD_W-1:FRAC_W];
    assign i1 = c1[COORD_W-1:FRAC_W];
    assign i2 = c2[COORD_W-1:FRAC_W];

    always_comb begin
        lo01 = (i0 < i1) ? i0 : i1;
        hi01 = (i0 > i1) ? i0 : i1;
        lo   = (lo01 < i2) ? lo01 : i2;
        hi   = (hi01 > i2) ? hi01 : i2;
    end

endmodule

// File: rtl/tri_setup.sv
// tri_setup: triangle setup stage. Latches one 144-bit packet, computes
// bounding box, edge coefficients A/B/C and twice the signed area using one
// shared 16x16 multiplier, and drops degenerate triangles.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   in_pkt, in_valid, in_ready  : packet input handshake
//   out_valid, out_ready        : result handshake
//   out_bbox, out_a, out_b,
//   out_c, out_area2, out_attr  : setup results (held until handshake)
//   out_cull_cnt                : saturating culled-triangle count
// Build option: TRI_SETUP_BACKFACE_CULL_EN also culls clockwise (area2 < 0).
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | in_ready=1, latch packet on in_valid
// ST_SETUP | A, B, bbox computed; C accumulators cleared
// ST_MUL   | k=0..5, one product per cycle into C(k/2)
// ST_AREA  | area2 = C0+C1+C2; cull or load outputs
// ST_OUT   | out_valid=1 until out_ready
module tri_setup
    import tri_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PKT_W-1:0]       in_pkt,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BBOX_W-1:0]      out_bbox,
    output logic [3*EDGE_AB_W-1:0] out_a,
    output logic [3*EDGE_AB_W-1:0] out_b,
    output logic [3*EDGE_C_W-1:0]  out_c,
    output logic [AREA_W-1:0]      out_area2,
    output logic [ATTR_W-1:0]      out_attr,
    output logic [CULL_W-1:0]      out_cull_cnt
);

    setup_state_e state_r, state_nx;

    vertex_t                 v_r [3];
    logic [ATTR_W-1:0]       attr_r;
    logic [2:0]              k_r;
    logic [EDGE_C_W-1:0]     c_acc [3];
    logic [3*EDGE_AB_W-1:0]  a_r, b_r, a_nx, b_nx;
    logic [BBOX_W-1:0]       bbox_r, bbox_nx;
    logic [INT_W-1:0]        xmin, xmax, ymin, ymax;

    logic [1:0]              edge_idx;
    vertex_t                 va, vb;
    logic [COORD_W-1:0]      mul_x, mul_y;
    logic [2*COORD_W-1:0]    prod;
    logic [AREA_W-1:0]       area_sum;
    logic                    cull;

    tri_bbox3 u_bbox_x (
        .c0 (v_r[0].x),
        .c1 (v_r[1].x),
        .c2 (v_r[2].x),
        .lo (xmin),
        .hi (xmax)
    );

    tri_bbox3 u_bbox_y (
        .c0 (v_r[0].y),
        .c1 (v_r[1].y),
        .c2 (v_r[2].y),
        .lo (ymin),
        .hi (ymax)
    );

    // Edge i runs v(i) -> v(i+1 mod 3)
    always_comb begin
        a_nx = {coord_diff(v_r[2].y, v_r[0].y),
                coord_diff(v_r[1].y, v_r[2].y),
                coord_diff(v_r[0].y, v_r[1].y)};
        b_nx = {coord_diff(v_r[0].x, v_r[2].x),
                coord_diff(v_r[2].x, v_r[1].x),
                coord_diff(v_r[1].x, v_r[0].x)};
        bbox_nx = {ymax, ymin, xmax, xmin};
    end

    // Shared multiplier: even k forms xa*yb, odd k forms xb*ya
    always_comb begin
        edge_idx = k_r[2:1];
        va = v_r[0];
        vb = v_r[1];
        case (edge_idx)
            2'd1: begin
                va = v_r[1];
                vb = v_r[2];
            end
            2'd2: begin
                va = v_r[2];
                vb = v_r[0];
            end
            default: ;
        endcase
        mul_x = k_r[0] ? vb.x : va.x;
        mul_y = k_r[0] ? va.y : vb.y;
        prod  = mul_x * mul_y;
    end

    always_comb begin
        area_sum = {{2{c_acc[0][EDGE_C_W-1]}}, c_acc[0]}
                 + {{2{c_acc[1][EDGE_C_W-1]}}, c_acc[1]}
                 + {{2{c_acc[2][EDGE_C_W-1]}}, c_acc[2]};
`ifdef TRI_SETUP_BACKFACE_CULL_EN
        cull = (area_sum == '0) || area_sum[AREA_W-1];
`else
        cull = (area_sum == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_nx;
    end

    always_comb begin
        state_nx  = state_r;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ST_SETUP;
            end
            ST_SETUP: state_nx = ST_MUL;
            ST_MUL:   if (k_r == 3'd5) state_nx = ST_AREA;
            ST_AREA:  state_nx = cull ? ST_IDLE : ST_OUT;
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = ST_IDLE;
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                v_r[i]   <= '0;
                c_acc[i] <= '0;
            end
            attr_r       <= '0;
            k_r          <= '0;
            a_r          <= '0;
            b_r          <= '0;
            bbox_r       <= '0;
            out_bbox     <= '0;
            out_a        <= '0;
            out_b        <= '0;
            out_c        <= '0;
            out_area2    <= '0;
            out_attr     <= '0;
            out_cull_cnt <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 3; i++) v_r[i] <= get_vertex(in_pkt, i);
                        attr_r <= in_pkt[OFS_ATTR +: ATTR_W];
                    end
                end
                ST_SETUP: begin
                    a_r    <= a_nx;
                    b_r    <= b_nx;
                    bbox_r <= bbox_nx;
                    k_r    <= '0;
                    for (int i = 0; i < 3; i++) c_acc[i] <= '0;
                end
                ST_MUL: begin
                    for (int i = 0; i < 3; i++) begin
                        if (edge_idx == 2'(i)) begin
                            c_acc[i] <= k_r[0] ? c_acc[i] - {1'b0, prod}
                                               : c_acc[i] + {1'b0, prod};
                        end
                    end
                    k_r <= (k_r == 3'd5) ? 3'd0 : k_r + 3'd1;
                end
                ST_AREA: begin
                    // Outputs only move for emitted triangles, so a culled
                    // one never disturbs the last delivered result.
                    if (cull) begin
                        if (out_cull_cnt != '1) out_cull_cnt <= out_cull_cnt + 1'b1;
                    end else begin
                        out_bbox  <= bbox_r;
                        out_a     <= a_r;
                        out_b     <= b_r;
                        out_c     <= {c_acc[2], c_acc[1], c_acc[0]};
                        out_area2 <= area_sum;
                        out_attr  <= attr_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
